// File: rtl/cdp1802_uart_pkg.sv
// Shared types and constants for the cdp1802 N-line UART peripheral.
package cdp1802_uart_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam logic [2:0] DEF_TX_PORT   = 3'd1;
    localparam logic [2:0] DEF_RX_PORT   = 3'd2;
    localparam int         NUM_DATA_BITS = 8;

endpackage

// File: rtl/cdp1802_uart_if.sv
// CPU-side N-line I/O bus between the cdp1802 core (master) and the UART (slave).
interface cdp1802_uart_if;

    logic [2:0] n;
    logic [7:0] cpu_bus_out;
    logic [7:0] cpu_bus_in;
    logic [3:0] EF;

    modport master (output n, output cpu_bus_out, input cpu_bus_in, input EF);
    modport slave  (input n, input cpu_bus_out, output cpu_bus_in, output EF);

endinterface

// File: rtl/uart_fifo.sv
// Byte FIFO with wrap-bit pointers; a pop and push in the same clock on a full
// FIFO both succeed.
module uart_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       resetq,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cdp1802_uart.sv
// 8N1 UART on the cdp1802 N-line bus: OUT TX_PORT queues a byte, INP RX_PORT pops one.
// Optional 4-entry TX FIFO with CDP1802_UART_TXFIFO_EN; default is a single holding register.
//
// TX state | meaning
//  IDLE    | line high, waiting for a queued byte
//  START   | driving the start bit
//  DATA    | shifting 8 data bits LSB first
//  STOP    | driving the stop bit, then chain to next byte or idle
// RX state | meaning
//  IDLE    | waiting for a falling edge
//  START   | half-bit wait, reject false starts
//  DATA    | mid-bit sampling of 8 data bits
//  STOP    | mid-stop sample: push or flag framing error
module cdp1802_uart
    import cdp1802_uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [2:0] TX_PORT      = DEF_TX_PORT,
    parameter logic [2:0] RX_PORT      = DEF_RX_PORT,
    parameter int         RX_DEPTH     = 4
) (
    input  logic                 clock,
    input  logic                 resetq,
    cdp1802_uart_if.slave        bus,
    input  logic                 uart_rx,
    output logic                 uart_tx
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(NUM_DATA_BITS - 1);

    logic w_tx_strobe;
    logic w_rx_strobe;

    assign w_tx_strobe = (bus.n == TX_PORT);
    assign w_rx_strobe = (bus.n == RX_PORT);

    tx_state_t        r_tx_state;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic [7:0]       r_tx_shift;
    logic             r_tx;

    logic       w_txq_pop;
    logic       w_txq_empty;
    logic       w_txq_full;
    logic [7:0] w_txq_head;
    logic       w_tx_load;

    assign w_tx_load = !w_txq_empty &&
                       ((r_tx_state == TX_IDLE) ||
                        (r_tx_state == TX_STOP && r_tx_cnt == '0));

`ifdef CDP1802_UART_TXFIFO_EN
    // The head stays queued through START so a full queue holds four bytes plus the one on the wire.
    assign w_txq_pop = (r_tx_state == TX_START) && (r_tx_cnt == '0);

    uart_fifo #(.DEPTH(4)) u_tx_fifo (
        .clock  (clock),
        .resetq (resetq),
        .push   (w_tx_strobe && !w_txq_full),
        .pop    (w_txq_pop),
        .din    (bus.cpu_bus_out),
        .dout   (w_txq_head),
        .full   (w_txq_full),
        .empty  (w_txq_empty)
    );
`else
    logic       r_hold_valid;
    logic [7:0] r_hold;

    assign w_txq_pop   = w_tx_load;
    assign w_txq_head  = r_hold;
    assign w_txq_empty = !r_hold_valid;
    assign w_txq_full  = r_hold_valid;

    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq) begin
            r_hold_valid <= 1'b0;
            r_hold       <= 8'h00;
        end else if (w_tx_strobe && !r_hold_valid) begin
            r_hold_valid <= 1'b1;
            r_hold       <= bus.cpu_bus_out;
        end else if (w_txq_pop) begin
            r_hold_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= 8'h00;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_load) begin
                        r_tx_state <= TX_START;
                        r_tx_cnt   <= BIT_LAST;
                        r_tx_shift <= w_txq_head;
                        r_tx       <= 1'b0;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == '0) begin
                        r_tx_state <= TX_DATA;
                        r_tx_cnt   <= BIT_LAST;
                        r_tx_bit   <= '0;
                        r_tx       <= r_tx_shift[0];
                    end else begin
                        r_tx_cnt <= r_tx_cnt - CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == '0) begin
                        r_tx_cnt <= BIT_LAST;
                        if (r_tx_bit == LAST_BIT) begin
                            r_tx_state <= TX_STOP;
                            r_tx       <= 1'b1;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx       <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt - CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == '0) begin
                        if (w_tx_load) begin
                            r_tx_state <= TX_START;
                            r_tx_cnt   <= BIT_LAST;
                            r_tx_shift <= w_txq_head;
                            r_tx       <= 1'b0;
                        end else begin
                            r_tx_state <= TX_IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt - CNT_W'(1);
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign uart_tx = r_tx;

    rx_state_t        r_rx_state;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    logic             r_rx_err;

    logic       w_rx_fall;
    logic       w_rx_stop_smp;
    logic       w_rx_push;
    logic       w_rx_ferr;
    logic       w_rx_ovr;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic [7:0] w_rx_head;

    assign w_rx_fall     = r_rx_prev && !r_rx_sync;
    assign w_rx_stop_smp = (r_rx_state == RX_STOP) && (r_rx_cnt == '0);
    assign w_rx_push     = w_rx_stop_smp && r_rx_sync;
    assign w_rx_ferr     = w_rx_stop_smp && !r_rx_sync;
    // A same-clock pop frees a slot in a full FIFO, so that case is not an overrun.
    assign w_rx_ovr      = w_rx_push && w_rx_full && !w_rx_strobe;

    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= 8'h00;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= HALF_LAST;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == '0) begin
                        if (r_rx_sync) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_state <= RX_DATA;
                            r_rx_cnt   <= BIT_LAST;
                            r_rx_bit   <= '0;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == '0) begin
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_cnt   <= BIT_LAST;
                        if (r_rx_bit == LAST_BIT) r_rx_state <= RX_STOP;
                        else                      r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == '0) r_rx_state <= RX_IDLE;
                    else                r_rx_cnt   <= r_rx_cnt - CNT_W'(1);
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq)                    r_rx_err <= 1'b0;
        else if (w_rx_ferr || w_rx_ovr) r_rx_err <= 1'b1;
        else if (w_rx_strobe)           r_rx_err <= 1'b0;
    end

    uart_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock  (clock),
        .resetq (resetq),
        .push   (w_rx_push),
        .pop    (w_rx_strobe),
        .din    (r_rx_shift),
        .dout   (w_rx_head),
        .full   (w_rx_full),
        .empty  (w_rx_empty)
    );

    assign bus.cpu_bus_in = (w_rx_strobe && !w_rx_empty) ? w_rx_head : 8'h00;
    assign bus.EF = {(r_tx_state != TX_IDLE) || !w_txq_empty,
                     r_rx_err,
                     !w_txq_full,
                     !w_rx_empty};

endmodule

// File: tb/tb_cdp1802_uart.sv
// Directed bench for cdp1802_uart at CLKS_PER_BIT=4; follows CDP1802_UART_TXFIFO_EN if defined.
module tb_cdp1802_uart;

    localparam int CPB = 4;

    logic clock;
    logic resetq;
    logic uart_rx;
    logic uart_tx;
    int   n_checks;
    int   n_errors;

    cdp1802_uart_if bus ();

    cdp1802_uart #(
        .CLKS_PER_BIT (CPB),
        .TX_PORT      (3'd1),
        .RX_PORT      (3'd2),
        .RX_DEPTH     (4)
    ) dut (
        .clock   (clock),
        .resetq  (resetq),
        .bus     (bus),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    // Checks one full frame, starting on the first clock of the start bit.
    task automatic chk_frame(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 10*CPB; k++) begin
            chk_val("tx_frame", {31'd0, uart_tx}, {31'd0, fr[k/CPB]});
            if (k == 10*CPB-1) chk_val("busy_in_stop", {31'd0, bus.EF[3]}, 32'd1);
            @(negedge clock);
        end
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clock);
        uart_rx = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] exp);
        bus.n = 3'd2;
        #1;
        chk_val(tag, {24'd0, bus.cpu_bus_in}, {24'd0, exp});
        @(negedge clock);
        bus.n = 3'd0;
    endtask

    task automatic wait_rx(input string tag);
        int t;
        t = 0;
        while (!bus.EF[0] && t < 60) begin
            @(negedge clock);
            t++;
        end
        chk_val(tag, {31'd0, bus.EF[0]}, 32'd1);
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        resetq          = 1'b0;
        uart_rx         = 1'b1;
        bus.n           = 3'd0;
        bus.cpu_bus_out = 8'h00;
        repeat (2) @(negedge clock);
        chk_val("rst_tx", {31'd0, uart_tx}, 32'd1);
        chk_val("rst_ef", {28'd0, bus.EF}, 32'h2);
        chk_val("rst_bus_in", {24'd0, bus.cpu_bus_in}, 32'h0);
        resetq = 1'b1;
        repeat (2) @(negedge clock);

        // Single byte from idle: start bit appears on the second edge after the strobe.
        bus.n = 3'd1; bus.cpu_bus_out = 8'hA5;
        @(negedge clock);
        bus.n = 3'd0;
        chk_val("tx_latency", {31'd0, uart_tx}, 32'd1);
        chk_val("busy_queued", {31'd0, bus.EF[3]}, 32'd1);
`ifdef CDP1802_UART_TXFIFO_EN
        chk_val("txq_room", {31'd0, bus.EF[1]}, 32'd1);
`else
        chk_val("hold_full", {31'd0, bus.EF[1]}, 32'd0);
`endif
        @(negedge clock);
        chk_val("hold_free", {31'd0, bus.EF[1]}, 32'd1);
        chk_frame(8'hA5);
        chk_val("tx_done_ef", {28'd0, bus.EF}, 32'h2);
        chk_val("tx_done_line", {31'd0, uart_tx}, 32'd1);
        repeat (3) @(negedge clock);

`ifdef CDP1802_UART_TXFIFO_EN
        bus.n = 3'd1; bus.cpu_bus_out = 8'h01;
        fork
            begin
                @(negedge clock);
                chk_val("fifo_latency", {31'd0, uart_tx}, 32'd1);
                @(negedge clock);
                chk_frame(8'h01);
                chk_frame(8'h02);
                chk_frame(8'h03);
                chk_frame(8'h04);
            end
            begin
                @(negedge clock); bus.cpu_bus_out = 8'h02;
                @(negedge clock); bus.cpu_bus_out = 8'h03;
                @(negedge clock); bus.cpu_bus_out = 8'h04;
                chk_val("txq_three", {31'd0, bus.EF[1]}, 32'd1);
                @(negedge clock); bus.cpu_bus_out = 8'h05;
                chk_val("txq_full", {31'd0, bus.EF[1]}, 32'd0);
                @(negedge clock); bus.n = 3'd0;
            end
        join
`else
        bus.n = 3'd1; bus.cpu_bus_out = 8'h5A;
        fork
            begin
                @(negedge clock);
                chk_val("b2b_latency", {31'd0, uart_tx}, 32'd1);
                @(negedge clock);
                chk_frame(8'h5A);
                chk_frame(8'hC3);
            end
            begin
                @(negedge clock); bus.n = 3'd0;
                @(negedge clock); bus.n = 3'd1; bus.cpu_bus_out = 8'hC3;
                @(negedge clock); bus.cpu_bus_out = 8'hFF;
                @(negedge clock); bus.n = 3'd0;
                chk_val("hold_drop_full", {31'd0, bus.EF[1]}, 32'd0);
            end
        join
`endif
        chk_val("queue_idle_busy", {31'd0, bus.EF[3]}, 32'd0);
        for (int k = 0; k < 12; k++) begin
            chk_val("no_extra_frame", {31'd0, uart_tx}, 32'd1);
            @(negedge clock);
        end

        rx_send(8'h3C, 1'b1);
        wait_rx("rx_ready");
        chk_val("rx_err_clean", {31'd0, bus.EF[2]}, 32'd0);
        rd_chk("rx_data_3c", 8'h3C);
        chk_val("rx_popped", {31'd0, bus.EF[0]}, 32'd0);
        chk_val("rx_bus_idle", {24'd0, bus.cpu_bus_in}, 32'h0);

        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        rx_send(8'h33, 1'b1);
        rx_send(8'h44, 1'b1);
        rx_send(8'h55, 1'b1);
        repeat (8) @(negedge clock);
        chk_val("ovr_err", {31'd0, bus.EF[2]}, 32'd1);
        chk_val("ovr_ready", {31'd0, bus.EF[0]}, 32'd1);
        rd_chk("ovr_rd0", 8'h11);
        chk_val("ovr_err_clr", {31'd0, bus.EF[2]}, 32'd0);
        rd_chk("ovr_rd1", 8'h22);
        rd_chk("ovr_rd2", 8'h33);
        rd_chk("ovr_rd3", 8'h44);
        chk_val("ovr_empty", {31'd0, bus.EF[0]}, 32'd0);
        rd_chk("empty_pop", 8'h00);

        rx_send(8'h99, 1'b0);
        repeat (8) @(negedge clock);
        chk_val("ferr_nopush", {31'd0, bus.EF[0]}, 32'd0);
        chk_val("ferr_flag", {31'd0, bus.EF[2]}, 32'd1);
        rd_chk("ferr_rd", 8'h00);
        chk_val("ferr_clr", {31'd0, bus.EF[2]}, 32'd0);

        uart_rx = 1'b0;
        @(negedge clock);
        uart_rx = 1'b1;
        repeat (50) @(negedge clock);
        chk_val("glitch_nopush", {31'd0, bus.EF[0]}, 32'd0);
        chk_val("glitch_noerr", {31'd0, bus.EF[2]}, 32'd0);
        rx_send(8'h81, 1'b1);
        wait_rx("post_glitch_ready");
        rd_chk("post_glitch_data", 8'h81);

        // Reset while the start bit is on the line.
        bus.n = 3'd1; bus.cpu_bus_out = 8'hA5;
        @(negedge clock);
        bus.n = 3'd0;
        repeat (3) @(negedge clock);
        chk_val("pre_rst_low", {31'd0, uart_tx}, 32'd0);
        #2;
        resetq = 1'b0;
        #1;
        chk_val("async_rst_tx", {31'd0, uart_tx}, 32'd1);
        chk_val("async_rst_ef", {28'd0, bus.EF}, 32'h2);
        @(negedge clock);
        resetq = 1'b1;
        @(negedge clock);
        bus.n = 3'd1; bus.cpu_bus_out = 8'h96;
        @(negedge clock);
        bus.n = 3'd0;
        @(negedge clock);
        chk_frame(8'h96);
        chk_val("post_rst_idle", {28'd0, bus.EF}, 32'h2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
